seven_seg_scan_driver: RTL and testbench

SEVEN_SEG_SCAN_DRIVER -- requirements
Module: seven_seg_scan_driver

---
 rtl/seven_seg_scan_driver.sv | 139 +++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_driver.sv
// Multiplexed seven-segment display driver.
// Holds a shadow copy of the digit data and scans one digit at a time.
// Each digit is held for SCAN_DIV clocks.
// Supports BCD or hex decoding, per-digit decimal points and
// leading-zero suppression.
// The display and digit-select outputs are registered.
module seven_seg_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic                    hex_en,
    input  logic                    lz_blank,
    output logic [7:0]              display,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = $clog2(SCAN_DIV);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PRE_W-1:0] LAST_PRE = PRE_W'(SCAN_DIV - 1);

    logic [PRE_W-1:0]        r_prescaler;
    logic [IDX_W-1:0]        r_index;
    logic [4*NUM_DIGITS-1:0] r_shData;
    logic [NUM_DIGITS-1:0]   r_shDp;
    logic                    r_shHex;
    logic                    r_shLz;
    logic [7:0]              r_display;
    logic [NUM_DIGITS-1:0]   r_an;

    logic [3:0]              w_nibble;
    logic                    w_dpBit;
    logic                    w_higherZero;
    logic                    w_blank;
    logic [6:0]              w_segs;
    logic [NUM_DIGITS-1:0]   w_anNext;

    // Segment patterns: bit0 = a ... bit6 = g.
    // In BCD mode the codes 10..15 are shown blank.
    function automatic logic [6:0] decodeNibble(input logic [3:0] nib, input logic hexMode);
        logic [6:0] segs;
        case (nib)
            4'h0: segs = 7'h3F;
            4'h1: segs = 7'h06;
            4'h2: segs = 7'h5B;
            4'h3: segs = 7'h4F;
            4'h4: segs = 7'h66;
            4'h5: segs = 7'h6D;
            4'h6: segs = 7'h7D;
            4'h7: segs = 7'h07;
            4'h8: segs = 7'h7F;
            4'h9: segs = 7'h6F;
            4'hA: segs = hexMode ? 7'h77 : 7'h00;
            4'hB: segs = hexMode ? 7'h7C : 7'h00;
            4'hC: segs = hexMode ? 7'h39 : 7'h00;
            4'hD: segs = hexMode ? 7'h5E : 7'h00;
            4'hE: segs = hexMode ? 7'h79 : 7'h00;
            default: segs = hexMode ? 7'h71 : 7'h00;
        endcase
        return segs;
    endfunction

    // Capture new display contents; decoding only ever looks at these copies
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shData <= '0;
            r_shDp   <= '0;
            r_shHex  <= 1'b0;
            r_shLz   <= 1'b0;
        end else if (load) begin
            r_shData <= data;
            r_shDp   <= dp;
            r_shHex  <= hex_en;
            r_shLz   <= lz_blank;
        end
    end

    // The prescaler paces the scan; the digit index steps when the prescaler wraps,
    // and both freeze while scanning is disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prescaler <= '0;
            r_index     <= '0;
        end else if (enable) begin
            if (r_prescaler == LAST_PRE) begin
                r_prescaler <= '0;
                r_index     <= (r_index == LAST_IDX) ? '0 : r_index + IDX_W'(1);
            end else begin
                r_prescaler <= r_prescaler + PRE_W'(1);
            end
        end
    end

    // Select the current digit's nibble and dp bit.
    // Also work out whether this digit and every digit above it are zero.
    always_comb begin
        w_nibble     = 4'h0;
        w_dpBit      = 1'b0;
        w_higherZero = 1'b1;
        w_anNext     = '0;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (j == int'(r_index)) begin
                w_nibble    = r_shData[4*j +: 4];
                w_dpBit     = r_shDp[j];
                w_anNext[j] = 1'b1;
            end
            if (j >= int'(r_index) && r_shData[4*j +: 4] != 4'h0) begin
                w_higherZero = 1'b0;
            end
        end
        w_blank = r_shLz && (r_index != '0) && w_higherZero;
        w_segs  = w_blank ? 7'h00 : decodeNibble(w_nibble, r_shHex);
    end

    // Register the lit digit and its segments.
    // Everything goes dark while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_display <= 8'h00;
            r_an      <= '0;
        end else if (enable) begin
            r_display <= {w_dpBit, w_segs};
            r_an      <= w_anNext;
        end else begin
            r_display <= 8'h00;
            r_an      <= '0;
        end
    end

    assign display = r_display;
    assign an      = r_an;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed testbench for seven_seg_scan_driver with 4 digits and SCAN_DIV=4.
// Each scenario task restarts the block from reset, loads a pattern, and
// compares outputs 1ns after rising edges against hand-computed values.
module tb_seven_seg_scan_driver;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic        load;
   logic [15:0] data;
   logic [3:0]  dp;
   logic        hex_en;
   logic        lz_blank;
   logic [7:0]  display;
   logic [3:0]  an;

   int nCompared;
   int nMismatched;

   logic [15:0] tabData [7];
   logic [3:0]  tabDp   [7];
   logic        tabHex  [7];
   logic        tabLz   [7];
   logic [7:0]  tabExp  [7][4];

   seven_seg_scan_driver #(
      .NUM_DIGITS(4),
      .SCAN_DIV  (4)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .enable  (enable),
      .load    (load),
      .data    (data),
      .dp      (dp),
      .hex_en  (hex_en),
      .lz_blank(lz_blank),
      .display (display),
      .an      (an)
   );

   // 10ns clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance to just after the next rising edge
   task automatic waitEdge();
      @(posedge clk);
      #1;
   endtask

   // Reset, then release with the given pattern loading on the first edge.
   // Returns just after that first edge; call it edge 1.
   task automatic applyStimulus(input logic [15:0] d, input logic [3:0] p,
                                input logic h, input logic z);
      @(negedge clk);
      rst_n    = 1'b0;
      enable   = 1'b1;
      load     = 1'b1;
      data     = d;
      dp       = p;
      hex_en   = h;
      lz_blank = z;
      @(negedge clk);
      rst_n = 1'b1;
      waitEdge();
      load = 1'b0;
   endtask

   // Outputs stay dark under reset, then digit 0 shows "0" on the first edge after release
   task automatic test_reset();
      rst_n = 1'b0; enable = 1'b1; load = 1'b0;
      data = 16'h0; dp = 4'h0; hex_en = 1'b0; lz_blank = 1'b0;
      repeat (3) waitEdge();
      nCompared++;
      if (display !== 8'h00) begin
         nMismatched++;
         $display("[TB] FAIL reset_display: got %h expected %h", display, 8'h00);
      end
      nCompared++;
      if (an !== 4'b0000) begin
         nMismatched++;
         $display("[TB] FAIL reset_an: got %b expected %b", an, 4'b0000);
      end
      @(negedge clk);
      rst_n = 1'b1;
      waitEdge();
      nCompared++;
      if (an !== 4'b0001) begin
         nMismatched++;
         $display("[TB] FAIL release_an: got %b expected %b", an, 4'b0001);
      end
      nCompared++;
      if (display !== 8'h3F) begin
         nMismatched++;
         $display("[TB] FAIL release_display: got %h expected %h", display, 8'h3F);
      end
   endtask

   // Full scan of 1234 in BCD: each digit is held 4 cycles and the scan wraps back to digit 0
   task automatic test_scan();
      logic [7:0] expSeg [4];
      int digit;
      expSeg[0] = 8'h66; expSeg[1] = 8'h4F; expSeg[2] = 8'h5B; expSeg[3] = 8'h06;
      applyStimulus(16'h1234, 4'b0000, 1'b0, 1'b0);
      nCompared++;
      if (display !== 8'h3F || an !== 4'b0001) begin
         nMismatched++;
         $display("[TB] FAIL scan_edge1: got %h/%b expected 3f/0001", display, an);
      end
      for (int k = 2; k <= 20; k++) begin
         waitEdge();
         digit = ((k - 1) / 4) % 4;
         nCompared++;
         if (an !== 4'(1 << digit)) begin
            nMismatched++;
            $display("[TB] FAIL scan_an k=%0d: got %b expected %b", k, an, 4'(1 << digit));
         end
         nCompared++;
         if (display !== expSeg[digit]) begin
            nMismatched++;
            $display("[TB] FAIL scan_display k=%0d: got %h expected %h", k, display, expSeg[digit]);
         end
      end
   endtask

   // Decode modes, leading-zero suppression, and dp handling across a table of patterns
   task automatic test_decode_table();
      int digit;
      tabData[0] = 16'h00A0; tabDp[0] = 4'b0000; tabHex[0] = 1'b1; tabLz[0] = 1'b1;
      tabExp[0][0] = 8'h3F; tabExp[0][1] = 8'h77; tabExp[0][2] = 8'h00; tabExp[0][3] = 8'h00;
      tabData[1] = 16'h00A0; tabDp[1] = 4'b0000; tabHex[1] = 1'b0; tabLz[1] = 1'b1;
      tabExp[1][0] = 8'h3F; tabExp[1][1] = 8'h00; tabExp[1][2] = 8'h00; tabExp[1][3] = 8'h00;
      tabData[2] = 16'h0000; tabDp[2] = 4'b0100; tabHex[2] = 1'b0; tabLz[2] = 1'b1;
      tabExp[2][0] = 8'h3F; tabExp[2][1] = 8'h00; tabExp[2][2] = 8'h80; tabExp[2][3] = 8'h00;
      tabData[3] = 16'hBCDE; tabDp[3] = 4'b0000; tabHex[3] = 1'b1; tabLz[3] = 1'b0;
      tabExp[3][0] = 8'h79; tabExp[3][1] = 8'h5E; tabExp[3][2] = 8'h39; tabExp[3][3] = 8'h7C;
      tabData[4] = 16'h90F0; tabDp[4] = 4'b1001; tabHex[4] = 1'b1; tabLz[4] = 1'b1;
      tabExp[4][0] = 8'hBF; tabExp[4][1] = 8'h71; tabExp[4][2] = 8'h3F; tabExp[4][3] = 8'hEF;
      tabData[5] = 16'h5678; tabDp[5] = 4'b0000; tabHex[5] = 1'b0; tabLz[5] = 1'b0;
      tabExp[5][0] = 8'h7F; tabExp[5][1] = 8'h07; tabExp[5][2] = 8'h7D; tabExp[5][3] = 8'h6D;
      tabData[6] = 16'h0C00; tabDp[6] = 4'b0000; tabHex[6] = 1'b0; tabLz[6] = 1'b1;
      tabExp[6][0] = 8'h3F; tabExp[6][1] = 8'h3F; tabExp[6][2] = 8'h00; tabExp[6][3] = 8'h00;
      for (int v = 0; v < 7; v++) begin
         applyStimulus(tabData[v], tabDp[v], tabHex[v], tabLz[v]);
         for (int k = 2; k <= 17; k++) begin
            waitEdge();
            digit = ((k - 1) / 4) % 4;
            nCompared++;
            if (display !== tabExp[v][digit] || an !== 4'(1 << digit)) begin
               nMismatched++;
               $display("[TB] FAIL decode v=%0d k=%0d: got %h/%b expected %h/%b",
                        v, k, display, an, tabExp[v][digit], 4'(1 << digit));
            end
         end
      end
   endtask

   // Dropping enable mid-digit blanks the outputs; scanning then resumes with the remaining count
   task automatic test_enable_hold();
      applyStimulus(16'h1234, 4'b0000, 1'b0, 1'b0);
      for (int k = 2; k <= 6; k++) waitEdge();
      nCompared++;
      if (display !== 8'h4F || an !== 4'b0010) begin
         nMismatched++;
         $display("[TB] FAIL hold_before: got %h/%b expected 4f/0010", display, an);
      end
      enable = 1'b0;
      for (int k = 7; k <= 16; k++) begin
         waitEdge();
         nCompared++;
         if (display !== 8'h00 || an !== 4'b0000) begin
            nMismatched++;
            $display("[TB] FAIL hold_dark k=%0d: got %h/%b expected 00/0000", k, display, an);
         end
      end
      enable = 1'b1;
      waitEdge();
      nCompared++;
      if (display !== 8'h4F || an !== 4'b0010) begin
         nMismatched++;
         $display("[TB] FAIL resume_1: got %h/%b expected 4f/0010", display, an);
      end
      waitEdge();
      nCompared++;
      if (display !== 8'h4F || an !== 4'b0010) begin
         nMismatched++;
         $display("[TB] FAIL resume_2: got %h/%b expected 4f/0010", display, an);
      end
      waitEdge();
      nCompared++;
      if (display !== 8'h5B || an !== 4'b0100) begin
         nMismatched++;
         $display("[TB] FAIL resume_3: got %h/%b expected 5b/0100", display, an);
      end
   endtask

   // A load in the middle of a digit changes that digit one cycle later and keeps the scan timing
   task automatic test_mid_load();
      applyStimulus(16'h1234, 4'b0000, 1'b0, 1'b0);
      for (int k = 2; k <= 6; k++) waitEdge();
      data = 16'h5678;
      load = 1'b1;
      waitEdge();
      load = 1'b0;
      nCompared++;
      if (display !== 8'h4F || an !== 4'b0010) begin
         nMismatched++;
         $display("[TB] FAIL midload_k7: got %h/%b expected 4f/0010", display, an);
      end
      waitEdge();
      nCompared++;
      if (display !== 8'h07 || an !== 4'b0010) begin
         nMismatched++;
         $display("[TB] FAIL midload_k8: got %h/%b expected 07/0010", display, an);
      end
      waitEdge();
      nCompared++;
      if (display !== 8'h7D || an !== 4'b0100) begin
         nMismatched++;
         $display("[TB] FAIL midload_k9: got %h/%b expected 7d/0100", display, an);
      end
   endtask

   // A load on the same edge as a digit advance shows the new data on the new digit
   task automatic test_back_to_back();
      applyStimulus(16'h1234, 4'b0000, 1'b0, 1'b0);
      for (int k = 2; k <= 7; k++) waitEdge();
      data = 16'h5678;
      load = 1'b1;
      waitEdge();
      load = 1'b0;
      nCompared++;
      if (display !== 8'h4F || an !== 4'b0010) begin
         nMismatched++;
         $display("[TB] FAIL advload_k8: got %h/%b expected 4f/0010", display, an);
      end
      waitEdge();
      nCompared++;
      if (display !== 8'h7D || an !== 4'b0100) begin
         nMismatched++;
         $display("[TB] FAIL advload_k9: got %h/%b expected 7d/0100", display, an);
      end
   endtask

   // A short reset pulse between edges blanks the outputs at once and discards the loaded data
   task automatic test_reset_midscan();
      applyStimulus(16'h1234, 4'b0000, 1'b0, 1'b0);
      for (int k = 2; k <= 9; k++) waitEdge();
      #2;
      rst_n = 1'b0;
      #1;
      nCompared++;
      if (display !== 8'h00 || an !== 4'b0000) begin
         nMismatched++;
         $display("[TB] FAIL async_reset: got %h/%b expected 00/0000", display, an);
      end
      #1;
      rst_n = 1'b1;
      waitEdge();
      nCompared++;
      if (display !== 8'h3F || an !== 4'b0001) begin
         nMismatched++;
         $display("[TB] FAIL after_pulse_1: got %h/%b expected 3f/0001", display, an);
      end
      waitEdge();
      nCompared++;
      if (display !== 8'h3F || an !== 4'b0001) begin
         nMismatched++;
         $display("[TB] FAIL after_pulse_2: got %h/%b expected 3f/0001", display, an);
      end
   endtask

   // Run every scenario in order, then report
   initial begin
      nCompared   = 0;
      nMismatched = 0;
      test_reset();
      test_scan();
      test_decode_table();
      test_enable_hold();
      test_mid_load();
      test_back_to_back();
      test_reset_midscan();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
